// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multi-cycle TSC control sequencer: FSM states,
// datapath mux select codes, opcode/func constants and the instruction
// class record produced by the decoder.
package mc_sequencer_pkg;

  // FSM states
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;  // PC + 1
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;  // PC-relative branch target
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;  // absolute jump target
  localparam logic [1:0] PC_SRC_REG    = 2'd3;  // register (JPR/JRL)

  // Register write-back source select
  localparam logic [1:0] WB_SRC_ALU = 2'd0;
  localparam logic [1:0] WB_SRC_MEM = 2'd1;
  localparam logic [1:0] WB_SRC_PC  = 2'd2;

  // Register write-back destination select
  localparam logic [1:0] WB_DST_RT   = 2'd0;
  localparam logic [1:0] WB_DST_RD   = 2'd1;
  localparam logic [1:0] WB_DST_LINK = 2'd2;

  // Primary opcodes, inst[15:12]
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_ALU = 4'd15;

  // Function codes used under OP_ALU, inst[5:0]
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // Instruction class flags; an all-zero record means an undefined opcode
  typedef struct packed {
    logic is_branch;  // BNE/BEQ/BGZ/BLZ
    logic is_jump;    // JMP/JAL/JPR/JRL
    logic is_jreg;    // jump target comes from a register (JPR/JRL)
    logic is_link;    // writes return address to $2 (JAL/JRL)
    logic is_load;    // LWD
    logic is_store;   // SWD
    logic is_rtype;   // ALU_OP register-register arithmetic
    logic is_imm;     // ADI/ORI/LHI
    logic is_halt;    // HLT
    logic is_wwd;     // WWD
  } inst_class_t;

  // Instructions whose work needs the EX stage
  function automatic logic needs_ex(input inst_class_t c);
    return c.is_branch | c.is_jreg | c.is_load | c.is_store | c.is_rtype | c.is_imm;
  endfunction

endpackage

// File: rtl/mc_sequencer_inst_class_decoder.sv
// Purely combinational classification of the current IR into the control
// classes the sequencer branches on.
module mc_sequencer_inst_class_decoder
  import mc_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [WORD_SIZE-1:0] inst_i,
  output inst_class_t          cls_o
);

  logic [3:0] opcode;
  logic [5:0] func;
  logic       unused_fields;

  assign opcode = inst_i[WORD_SIZE-1 -: 4];
  assign func   = inst_i[5:0];
  // Register/immediate fields are the datapath's business, not ours
  assign unused_fields = ^inst_i[WORD_SIZE-5:6];

  // Opcode/func to class flags; unknown opcodes leave every flag clear
  always_comb begin
    cls_o = '0;
    unique case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls_o.is_branch = 1'b1;
      OP_ADI, OP_ORI, OP_LHI:         cls_o.is_imm    = 1'b1;
      OP_LWD:                         cls_o.is_load   = 1'b1;
      OP_SWD:                         cls_o.is_store  = 1'b1;
      OP_JMP:                         cls_o.is_jump   = 1'b1;
      OP_JAL: begin
        cls_o.is_jump = 1'b1;
        cls_o.is_link = 1'b1;
      end
      OP_ALU: begin
        unique case (func)
          FN_JPR: begin
            cls_o.is_jump = 1'b1;
            cls_o.is_jreg = 1'b1;
          end
          FN_JRL: begin
            cls_o.is_jump = 1'b1;
            cls_o.is_jreg = 1'b1;
            cls_o.is_link = 1'b1;
          end
          FN_WWD:  cls_o.is_wwd   = 1'b1;
          FN_HLT:  cls_o.is_halt  = 1'b1;
          default: cls_o.is_rtype = 1'b1;
        endcase
      end
      default: cls_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM for the 16-bit TSC datapath. Walks each
// instruction through IF/ID/EX/MEM/WB over a shared single-port memory
// with a request/ready handshake, drives datapath enables and muxes,
// counts retired instructions and parks in HALT after HLT.
module mc_sequencer
  import mc_sequencer_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] inst,
  input  logic                 branch_cond,
  input  logic                 mem_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           wb_src,
  output logic [1:0]           wb_dst,
  output logic                 wwd_valid,
  output logic                 is_halted,
  output logic [CNT_WIDTH-1:0] num_inst
);

  state_e                 state_q, state_d;
  logic   [CNT_WIDTH-1:0] num_inst_q;
  logic                   retire;
  inst_class_t            cls;

  mc_sequencer_inst_class_decoder #(
    .WORD_SIZE (WORD_SIZE)
  ) u_decoder (
    .inst_i (inst),
    .cls_o  (cls)
  );

  // Next state, retire strobe and all control outputs; reset masks everything
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_SEQ;
    reg_write    = 1'b0;
    wb_src       = WB_SRC_ALU;
    wb_dst       = WB_DST_RT;
    wwd_valid    = 1'b0;
    is_halted    = 1'b0;

    if (reset_n) begin
      unique case (state_q)
        S_IF: begin
          // Fetch from PC; hold the request until memory answers
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_ID;
          end
        end

        S_ID: begin
          if (cls.is_jump && !cls.is_jreg) begin
            // JMP/JAL finish here; JAL also links PC into $2
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            if (cls.is_link) begin
              reg_write = 1'b1;
              wb_src    = WB_SRC_PC;
              wb_dst    = WB_DST_LINK;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end else if (cls.is_halt) begin
            retire  = 1'b1;
            state_d = S_HALT;
          end else if (cls.is_wwd) begin
            wwd_valid = 1'b1;
            retire    = 1'b1;
            state_d   = S_IF;
          end else if (needs_ex(cls)) begin
            state_d = S_EX;
          end else begin
            // Undefined opcode: retire as a no-op
            retire  = 1'b1;
            state_d = S_IF;
          end
        end

        S_EX: begin
          if (cls.is_branch) begin
            pc_write = branch_cond;
            pc_src   = PC_SRC_BRANCH;
            retire   = 1'b1;
            state_d  = S_IF;
          end else if (cls.is_jreg) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
            if (cls.is_link) begin
              reg_write = 1'b1;
              wb_src    = WB_SRC_PC;
              wb_dst    = WB_DST_LINK;
            end
            retire  = 1'b1;
            state_d = S_IF;
          end else if (cls.is_load || cls.is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end

        S_MEM: begin
          // Data access at the ALU-computed address; read and write are exclusive
          mem_addr_sel = 1'b1;
          mem_read     = cls.is_load;
          mem_write    = cls.is_store;
          if (mem_ready) begin
            if (cls.is_store) begin
              retire  = 1'b1;
              state_d = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end

        S_WB: begin
          reg_write = 1'b1;
          wb_src    = cls.is_load  ? WB_SRC_MEM : WB_SRC_ALU;
          wb_dst    = cls.is_rtype ? WB_DST_RD  : WB_DST_RT;
          retire    = 1'b1;
          state_d   = S_IF;
        end

        S_HALT: begin
          is_halted = 1'b1;
          state_d   = S_HALT;
        end

        default: state_d = S_IF;
      endcase
    end
  end

  // State register; reset drops any outstanding request by returning to IF
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_inst_q <= '0;
    end else if (retire) begin
      num_inst_q <= num_inst_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign num_inst = num_inst_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer. Inputs change on the falling edge and
// outputs are sampled 1 time unit later; each task walks one instruction
// scenario cycle by cycle against hand-derived control vectors.
module tb_mc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] inst;
  logic        branch_cond;
  logic        mem_ready;
  logic        mem_read, mem_write, mem_addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic [1:0]  wb_src, wb_dst;
  logic        wwd_valid, is_halted;
  logic [15:0] num_inst;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [13:0] exp;

  mc_sequencer #(.WORD_SIZE(16), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inst         (inst),
    .branch_cond  (branch_cond),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr_sel (mem_addr_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_src       (wb_src),
    .wb_dst       (wb_dst),
    .wwd_valid    (wwd_valid),
    .is_halted    (is_halted),
    .num_inst     (num_inst)
  );

  always #5 clk = ~clk;

  wire [13:0] ctl = {mem_read, mem_write, mem_addr_sel, ir_write, pc_write, pc_src,
                     reg_write, wb_src, wb_dst, wwd_valid, is_halted};

  // Packs an expected control vector in the same order as ctl
  function automatic logic [13:0] exp_ctl(input logic rd, input logic wr, input logic as,
      input logic irw, input logic pcw, input logic [1:0] pcs, input logic rw,
      input logic [1:0] wbs, input logic [1:0] wbd, input logic wwd, input logic hlt);
    return {rd, wr, as, irw, pcw, pcs, rw, wbs, wbd, wwd, hlt};
  endfunction

  // One clock cycle: drive on the falling edge, settle, then caller samples
  task automatic cyc(input logic rdy, input logic bc);
    @(negedge clk);
    mem_ready   = rdy;
    branch_cond = bc;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; inst = 16'h0000; mem_ready = 1'b0; branch_cond = 1'b0;
    @(negedge clk); #1;
    exp = '0;
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL reset_outputs: ctl=%b expected %b", ctl, exp); end
    repeat (2) @(posedge clk);
    @(negedge clk); mem_ready = 1'b1; #1;
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL reset_masks_ready: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd0) begin tests_failed++; $display("FAIL reset_count: num_inst=%0d expected 0", num_inst); end
    @(negedge clk); reset_n = 1'b1; mem_ready = 1'b0; #1;
    exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL reset_release_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd0) begin tests_failed++; $display("FAIL reset_release_count: num_inst=%0d expected 0", num_inst); end
  endtask

  task automatic test_adi();
    // Two more wait cycles (the release cycle was the first), then ready
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0);
      exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL adi_if_wait%0d: ctl=%b expected %b", i, ctl, exp); end
    end
    cyc(1, 0);
    exp = exp_ctl(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL adi_if_ready: ctl=%b expected %b", ctl, exp); end
    inst = 16'h4105;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0);
      exp = '0;
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL adi_idle_stage%0d: ctl=%b expected %b", i, ctl, exp); end
    end
    cyc(1, 0);
    exp = exp_ctl(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL adi_wb: ctl=%b expected %b", ctl, exp); end
    cyc(0, 0);
    exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL adi_next_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd1) begin tests_failed++; $display("FAIL adi_count: num_inst=%0d expected 1", num_inst); end
  endtask

  task automatic test_lwd_swd();
    cyc(1, 0);
    inst = 16'h7000;
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 0);
    exp = exp_ctl(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL lwd_mem: ctl=%b expected %b", ctl, exp); end
    cyc(1, 0);
    exp = exp_ctl(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL lwd_wb: ctl=%b expected %b", ctl, exp); end
    cyc(1, 0);
    exp = exp_ctl(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL lwd_then_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd2) begin tests_failed++; $display("FAIL lwd_count: num_inst=%0d expected 2", num_inst); end
    inst = 16'h8000;
    cyc(1, 0);
    cyc(1, 0);
    cyc(1, 0);
    exp = exp_ctl(0,1,1,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL swd_mem: ctl=%b expected %b", ctl, exp); end
    cyc(0, 0);
    exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL swd_then_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd3) begin tests_failed++; $display("FAIL swd_count: num_inst=%0d expected 3", num_inst); end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      cyc(1, 0);
      inst = 16'h1000;
      cyc(0, 1);
      exp = '0;
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL beq%0d_id: ctl=%b expected %b", t, ctl, exp); end
      cyc(0, (t == 0));
      exp = exp_ctl(0,0,0,0,(t == 0),2'd1,0,2'd0,2'd0,0,0);
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL beq%0d_ex: ctl=%b expected %b", t, ctl, exp); end
      cyc(0, 0);
      exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL beq%0d_next_if: ctl=%b expected %b", t, ctl, exp); end
      tests_run++;
      if (num_inst !== 16'(4 + t)) begin tests_failed++; $display("FAIL beq%0d_count: num_inst=%0d expected %0d", t, num_inst, 4 + t); end
    end
  endtask

  task automatic test_jal();
    cyc(1, 0);
    inst = 16'hA010;
    cyc(0, 0);
    exp = exp_ctl(0,0,0,0,1,2'd2,1,2'd2,2'd2,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL jal_id: ctl=%b expected %b", ctl, exp); end
    cyc(0, 0);
    exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL jal_next_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd6) begin tests_failed++; $display("FAIL jal_count: num_inst=%0d expected 6", num_inst); end
  endtask

  task automatic test_wwd_jrl_undef();
    cyc(1, 0);
    inst = 16'hF01C;
    cyc(0, 0);
    exp = exp_ctl(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL wwd_id: ctl=%b expected %b", ctl, exp); end
    cyc(1, 0);
    inst = 16'hF01A;
    cyc(0, 0);
    cyc(0, 0);
    exp = exp_ctl(0,0,0,0,1,2'd3,1,2'd2,2'd2,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL jrl_ex: ctl=%b expected %b", ctl, exp); end
    cyc(1, 0);
    inst = 16'hB000;
    cyc(0, 0);
    exp = '0;
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL undef_id: ctl=%b expected %b", ctl, exp); end
    cyc(0, 0);
    exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL undef_next_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd9) begin tests_failed++; $display("FAIL undef_count: num_inst=%0d expected 9", num_inst); end
  endtask

  task automatic test_halt();
    cyc(1, 0);
    inst = 16'hF01D;
    cyc(0, 0);
    exp = '0;
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL hlt_id: ctl=%b expected %b", ctl, exp); end
    for (int i = 0; i < 20; i++) begin
      cyc(i[0], 0);
      exp = exp_ctl(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,1);
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL halt_hold%0d: ctl=%b expected %b", i, ctl, exp); end
      tests_run++;
      if (num_inst !== 16'd10) begin tests_failed++; $display("FAIL halt_count%0d: num_inst=%0d expected 10", i, num_inst); end
    end
  endtask

  task automatic test_reset_mid_mem();
    @(negedge clk); reset_n = 1'b0; mem_ready = 1'b0; #1;
    exp = '0;
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL halt_reset: ctl=%b expected %b", ctl, exp); end
    @(negedge clk); reset_n = 1'b1; #1;
    tests_run++;
    if (num_inst !== 16'd0) begin tests_failed++; $display("FAIL halt_reset_count: num_inst=%0d expected 0", num_inst); end
    cyc(1, 0);
    inst = 16'h8000;
    cyc(0, 0);
    cyc(0, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0);
      exp = exp_ctl(0,1,1,0,0,2'd0,0,2'd0,2'd0,0,0);
      tests_run++;
      if (ctl !== exp) begin tests_failed++; $display("FAIL swd_stall%0d: ctl=%b expected %b", i, ctl, exp); end
    end
    @(negedge clk); reset_n = 1'b0; #1;
    exp = '0;
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL stall_reset_mask: ctl=%b expected %b", ctl, exp); end
    @(negedge clk); reset_n = 1'b1; #1;
    exp = exp_ctl(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,0);
    tests_run++;
    if (ctl !== exp) begin tests_failed++; $display("FAIL stall_reset_if: ctl=%b expected %b", ctl, exp); end
    tests_run++;
    if (num_inst !== 16'd0) begin tests_failed++; $display("FAIL stall_reset_count: num_inst=%0d expected 0", num_inst); end
  endtask

  initial begin
    test_reset();
    test_adi();
    test_lwd_swd();
    test_beq();
    test_jal();
    test_wwd_jrl_undef();
    test_halt();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
